// File: rtl/uart_tx_avalon_writer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_avalon_writer
// Brief    : Avalon-MM master that drains a byte FIFO into a UART txdata
//            register, polling the status register for TRDY before each byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_avalon_writer #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned TXDATA_ADDR = 1,
    parameter int unsigned STATUS_ADDR = 2,
    parameter int unsigned TRDY_BIT    = 6
) (
    input  logic                          clock_sink_clk,
    input  logic                          reset_sink_reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [ADDR_WIDTH-1:0]         avalon_master_address,
    output logic                          avalon_master_read,
    input  logic [15:0]                   avalon_master_readdata,
    input  logic                          avalon_master_readdatavalid,
    input  logic                          avalon_master_waitrequest,
    output logic                          avalon_master_write,
    output logic [15:0]                   avalon_master_writedata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int unsigned            c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int unsigned            c_cnt_w     = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]     c_full      = c_cnt_w'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  c_addr_tx   = ADDR_WIDTH'(TXDATA_ADDR);
    localparam logic [ADDR_WIDTH-1:0]  c_addr_stat = ADDR_WIDTH'(STATUS_ADDR);
    localparam logic [3:0]             c_trdy_idx  = 4'(TRDY_BIT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_POLL_RD   = 2'd1,
        ST_POLL_WAIT = 2'd2,
        ST_WRITE     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [c_ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]      count_q, count_d;
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [15:0]             writedata_q, writedata_d;
    logic                    busy_q, busy_d;
    logic [7:0]              mem_q [FIFO_DEPTH];

    logic                    w_push;
    logic                    w_pop;
    logic                    w_trdy;
    logic                    w_unused_readdata;

    assign tx_ready                = (count_q < c_full);
    assign fifo_count              = count_q;
    assign avalon_master_read      = read_q;
    assign avalon_master_write     = write_q;
    assign avalon_master_address   = address_q;
    assign avalon_master_writedata = writedata_q;
    assign busy                    = busy_q;
    assign w_trdy                  = avalon_master_readdata[c_trdy_idx];
    // Only the TRDY bit matters; the rest of the status word is ignored.
    assign w_unused_readdata       = ^avalon_master_readdata;

    // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        w_push   = tx_valid && tx_ready;
        w_pop    = (state_q == ST_WRITE) && !avalon_master_waitrequest;
        wr_ptr_d = w_push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
        count_d  = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_cnt_w'(1);
        end
    end

    // Next-state and next-output logic; bus outputs are computed one cycle ahead so they leave flops.
    always_comb begin
        state_d     = state_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        address_d   = address_q;
        writedata_d = writedata_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d   = ST_POLL_RD;
                    read_d    = 1'b1;
                    address_d = c_addr_stat;
                end
            end
            ST_POLL_RD: begin
                if (avalon_master_waitrequest) begin
                    read_d = 1'b1;
                end else begin
                    state_d = ST_POLL_WAIT;
                end
            end
            ST_POLL_WAIT: begin
                if (avalon_master_readdatavalid) begin
                    if (w_trdy) begin
                        state_d     = ST_WRITE;
                        write_d     = 1'b1;
                        address_d   = c_addr_tx;
                        writedata_d = {8'h00, mem_q[rd_ptr_q]};
                    end else begin
                        state_d   = ST_POLL_RD;
                        read_d    = 1'b1;
                        address_d = c_addr_stat;
                    end
                end
            end
            ST_WRITE: begin
                if (avalon_master_waitrequest) begin
                    write_d = 1'b1;
                end else if (count_d != '0) begin
                    state_d   = ST_POLL_RD;
                    read_d    = 1'b1;
                    address_d = c_addr_stat;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Register FSM state, FIFO control and all bus outputs.
    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            busy_q      <= busy_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clock_sink_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_avalon_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_avalon_writer
// Brief    : Directed self-checking bench for uart_tx_avalon_writer with a
//            small in-bench UART slave and byte producer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_avalon_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [4:0]  address;
    logic        read;
    logic [15:0] readdata;
    logic        rdv;
    logic        waitrequest;
    logic        write;
    logic [15:0] writedata;
    logic [3:0]  fifo_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  prod_q[$];
    logic [15:0] wr_log[$];
    byte         ev_q[$];
    bit          trdy_q[$];
    bit          trdy_default;
    int          wr_stall;
    int          n_reads;
    bit          rdv_pending;
    logic [15:0] rdv_data;
    bit          rdv_drop;
    bit          force_rdv;

    always #5 clk = ~clk;

    uart_tx_avalon_writer dut (
        .clock_sink_clk              (clk),
        .reset_sink_reset            (rst),
        .tx_data                     (tx_data),
        .tx_valid                    (tx_valid),
        .tx_ready                    (tx_ready),
        .avalon_master_address       (address),
        .avalon_master_read          (read),
        .avalon_master_readdata      (readdata),
        .avalon_master_readdatavalid (rdv),
        .avalon_master_waitrequest   (waitrequest),
        .avalon_master_write         (write),
        .avalon_master_writedata     (writedata),
        .fifo_count                  (fifo_count),
        .busy                        (busy)
    );

    // One bus cycle: drive producer/slave inputs, record handshakes, advance past the edge.
    task automatic tick();
        bit push_acc, rd_acc, wr_acc;
        tx_valid = (prod_q.size() != 0);
        tx_data  = tx_valid ? prod_q[0] : 8'h00;
        if (write && wr_stall > 0) begin
            waitrequest = 1'b1;
            wr_stall--;
        end else begin
            waitrequest = 1'b0;
        end
        rdv      = rdv_pending || force_rdv;
        readdata = rdv_pending ? rdv_data : (force_rdv ? 16'h0040 : 16'h0000);
        force_rdv = 1'b0;
        push_acc = tx_valid && tx_ready;
        rd_acc   = read && !waitrequest && !rst;
        wr_acc   = write && !waitrequest && !rst;
        if (read && write) begin
            checks++; errors++;
            $display("FAIL rd_wr_overlap: read=%0b write=%0b, required not both high", read, write);
        end
        if (rd_acc) begin
            checks++;
            if (address !== 5'd2) begin
                errors++;
                $display("FAIL read_addr: got %0d, required 2", address);
            end
            n_reads++;
            ev_q.push_back(0);
        end
        if (wr_acc) begin
            checks++;
            if (address !== 5'd1) begin
                errors++;
                $display("FAIL write_addr: got %0d, required 1", address);
            end
            wr_log.push_back(writedata);
            ev_q.push_back(1);
        end
        @(posedge clk);
        #1;
        if (push_acc) void'(prod_q.pop_front());
        rdv_pending = rd_acc && !rdv_drop && !rst;
        if (rd_acc) begin
            if (trdy_q.size() != 0) rdv_data = trdy_q.pop_front() ? 16'h0040 : 16'hFFBF;
            else                    rdv_data = trdy_default     ? 16'h0040 : 16'hFFBF;
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        ev_q.delete();
        n_reads = 0;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            tick();
            if (prod_q.size() == 0 && fifo_count == 0 && !busy && !read && !write) break;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL %s_timeout: not idle after %0d cycles (fifo_count=%0d busy=%0b)", name, budget, fifo_count, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({read, write, busy, tx_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl: read/write/busy/tx_ready=%b, required 0001", {read, write, busy, tx_ready});
        end
        checks++;
        if (address !== 5'd0 || writedata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bus: address=%0h writedata=%0h, required 0 and 0", address, writedata);
        end
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", fifo_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_logs();
        prod_q.push_back(8'h41);
        tick();
        checks++;
        if (fifo_count !== 4'd1 || read !== 1'b0) begin
            errors++;
            $display("FAIL single_push: fifo_count=%0d read=%0b, required 1 and 0", fifo_count, read);
        end
        tick();
        checks++;
        if (read !== 1'b1 || address !== 5'd2) begin
            errors++;
            $display("FAIL single_latency: read=%0b address=%0d, required 1 and 2", read, address);
        end
        run_until_idle(30, "single");
        checks++;
        if (n_reads != 1 || wr_log.size() != 1) begin
            errors++;
            $display("FAIL single_counts: reads=%0d writes=%0d, required 1 and 1", n_reads, wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== 16'h0041) begin
                errors++;
                $display("FAIL single_data: got %h, required 0041", wr_log[0]);
            end
        end
        checks++;
        if (fifo_count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: fifo_count=%0d busy=%0b, required 0 and 0", fifo_count, busy);
        end
    endtask

    task automatic test_back_to_back();
        byte exp_ev[6] = '{0, 1, 0, 1, 0, 1};
        logic [15:0] exp_wr[3] = '{16'h0010, 16'h0020, 16'h0030};
        bit ok;
        clear_logs();
        prod_q.push_back(8'h10);
        prod_q.push_back(8'h20);
        prod_q.push_back(8'h30);
        run_until_idle(60, "b2b");
        checks++;
        if (wr_log.size() != 3 || n_reads != 3) begin
            errors++;
            $display("FAIL b2b_counts: writes=%0d reads=%0d, required 3 and 3", wr_log.size(), n_reads);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_log[i] !== exp_wr[i]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h, required %h", i, wr_log[i], exp_wr[i]);
                end
            end
        end
        ok = (ev_q.size() == 6);
        for (int i = 0; i < 6 && ok; i++) if (ev_q[i] != exp_ev[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_order: %0d bus events not read/write interleaved, required R W R W R W", ev_q.size());
        end
    endtask

    task automatic test_trdy_poll();
        bit ok;
        clear_logs();
        trdy_q = '{0, 0, 0, 1};
        prod_q.push_back(8'h55);
        run_until_idle(60, "poll");
        checks++;
        if (n_reads != 4 || wr_log.size() != 1) begin
            errors++;
            $display("FAIL poll_counts: reads=%0d writes=%0d, required 4 and 1", n_reads, wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== 16'h0055) begin
                errors++;
                $display("FAIL poll_data: got %h, required 0055", wr_log[0]);
            end
        end
        ok = (ev_q.size() == 5);
        for (int i = 0; i < 4 && ok; i++) if (ev_q[i] != 0) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL poll_order: %0d events, required 4 reads then the write", ev_q.size());
        end
    endtask

    task automatic test_write_stall();
        int k;
        clear_logs();
        wr_stall = 5;
        prod_q.push_back(8'h5A);
        for (k = 0; k < 20 && !write; k++) tick();
        checks++;
        if (!write) begin
            errors++;
            $display("FAIL stall_start: write=%0b after %0d cycles, required 1", write, k);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (write !== 1'b1 || address !== 5'd1 || writedata !== 16'h005A || fifo_count !== 4'd1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: write=%0b addr=%0d data=%h count=%0d, required 1 1 005A 1",
                         i, write, address, writedata, fifo_count);
            end
        end
        tick();
        checks++;
        if (fifo_count !== 4'd0 || wr_log.size() != 1) begin
            errors++;
            $display("FAIL stall_pop: fifo_count=%0d writes=%0d, required 0 and 1", fifo_count, wr_log.size());
        end
        run_until_idle(20, "stall");
    endtask

    task automatic test_full_wrap();
        clear_logs();
        trdy_default = 1'b0;
        for (int i = 0; i < 9; i++) prod_q.push_back(8'h80 + 8'(i));
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (fifo_count !== 4'd8 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: fifo_count=%0d tx_ready=%0b, required 8 and 0", fifo_count, tx_ready);
        end
        checks++;
        if (prod_q.size() != 1 || wr_log.size() != 0) begin
            errors++;
            $display("FAIL full_hold: producer left=%0d writes=%0d, required 1 and 0", prod_q.size(), wr_log.size());
        end
        trdy_default = 1'b1;
        run_until_idle(200, "full");
        checks++;
        if (wr_log.size() != 9) begin
            errors++;
            $display("FAIL full_count: writes=%0d, required 9", wr_log.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (wr_log[i] !== {8'h00, 8'h80 + 8'(i)}) begin
                    errors++;
                    $display("FAIL full_data[%0d]: got %h, required %h", i, wr_log[i], {8'h00, 8'h80 + 8'(i)});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_logs();
        rdv_drop = 1'b1;
        prod_q.push_back(8'h01);
        prod_q.push_back(8'h02);
        prod_q.push_back(8'h03);
        for (k = 0; k < 20 && n_reads == 0; k++) tick();
        checks++;
        if (n_reads != 1 || fifo_count !== 4'd3 || !busy) begin
            errors++;
            $display("FAIL mid_setup: reads=%0d fifo_count=%0d busy=%0b, required 1 3 1", n_reads, fifo_count, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdv_drop = 1'b0;
        checks++;
        if ({read, write, busy} !== 3'b000 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: read/write/busy=%b fifo_count=%0d, required 000 and 0", {read, write, busy}, fifo_count);
        end
        clear_logs();
        force_rdv = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (wr_log.size() != 0 || n_reads != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_stray: writes=%0d reads=%0d busy=%0b, required 0 0 0", wr_log.size(), n_reads, busy);
        end
    endtask

    initial begin
        rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; readdata = 16'h0000;
        rdv = 1'b0; waitrequest = 1'b0;
        trdy_default = 1'b1; wr_stall = 0; n_reads = 0;
        rdv_pending = 1'b0; rdv_data = 16'h0000; rdv_drop = 1'b0; force_rdv = 1'b0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_trdy_poll();
        test_write_stall();
        test_full_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
